ctrl_unit_mc: RTL and testbench
===============================

// Module: ctrl_unit_mc
// PURPOSE
//  Parametrised multi-cycle control unit for the accumulator CPU. Sequences fetch/decode/execute,
//  drives AR/IR/AC/OR load strobes and the ALU select S, and handshakes with memory (Req/Ack) so slow
//  memories stall the core. Adds halt, run-gating, illegal-instruction detection, memory-wait
//  watchdog and a retired-instruction counter. Sits between datapath registers and memory.
// PARAMETERS
//  IW       16  instruction width
//  ALU_OPS  8   one-hot ALU op field width, IR[ALU_OPS-1:0]; S = bit index+1
//  SW       4   width of S; must satisfy 2**SW > ALU_OPS
//  RD_BIT   9   IR bit: memory read into OR
//  WR_BIT   8   IR bit: memory write
//  HLT_BIT  15  IR bit: halt
//  WAIT_MAX 15  max cycles waiting for Mem_Ack before timeout (>=1)
//  CNT_W    16  retired-instruction counter width
// PORTS
//  Clock_Puls  in   1      clock, all state on rising edge
//  Reset       in   1      synchronous, active-high
//  Run         in   1      1 = allow a new fetch; 0 = hold in S_FETCH
//  IR          in   IW     instruction register contents (valid from S_DECODE on)
//  Mem_Ack     in   1      memory completes current request this cycle
//  Mem_Req     out  1      memory request active
//  Rd          out  1      read request (instruction fetch or data read)
//  Wr          out  1      data write request
//  Load_AR     out  1      load address register
//  Load_IR     out  1      load instruction register
//  Load_AC     out  1      load accumulator from ALU
//  Load_OR     out  1      load operand register from memory
//  S           out  SW     registered ALU select; 0 = no ALU op
//  Halted      out  1      core in S_HALT
//  Illegal     out  1      sticky: illegal instruction seen since reset
//  Timeout     out  1      one-cycle pulse: Mem_Ack watchdog expired
//  Instr_Cnt   out  CNT_W  retired instructions, wraps to 0
// BEHAVIOUR
//  Reset: state S_FETCH, all outputs 0, S=0, Instr_Cnt=0, wait counter 0. Reset wins over all events,
//   including mid-request; outstanding memory request is dropped (Mem_Req=0 next cycle).
//  S_FETCH: if Run: Load_AR=1 one cycle -> S_IFETCH; else stay, all strobes 0.
//  S_IFETCH: Mem_Req=1, Rd=1 until Mem_Ack. Ack cycle: Load_IR=1 -> S_DECODE.
//  S_DECODE (1 cycle, strobes 0): IR[HLT_BIT] -> S_HALT. Illegal if >1 bit set in ALU field or RD_BIT
//   and WR_BIT both set: set Illegal, S=0, -> S_FETCH (not retired). Else register S (one-hot index+1,
//   0 if field zero) -> S_EXEC.
//  S_EXEC: no memory bit: single cycle, Load_AC=(S!=0), retire -> S_FETCH. RD_BIT: Mem_Req=Rd=1 until
//   Ack; Ack cycle: Load_OR=1, Load_AC=(S!=0), retire. WR_BIT: Mem_Req=Wr=1 until Ack; Ack cycle:
//   Load_AC=(S!=0), retire. Minimum instruction = 4 cycles (FETCH,IFETCH w/ same-cycle Ack,DECODE,EXEC).
//  Retire: Instr_Cnt+1 on the retiring EXEC cycle, modulo 2**CNT_W.
//  Watchdog: counter increments every cycle Mem_Req=1 and no Ack, cleared on leaving wait. Reaching
//   WAIT_MAX: Timeout=1 for one cycle, abandon request, -> S_FETCH, no retire, no loads. Ack on same
//   cycle as expiry: Ack wins, no Timeout.
//  S_HALT: Halted=1, all strobes 0, S held; exit only by Reset.
//  Mem_Ack while Mem_Req=0: ignored. Run only sampled in S_FETCH.
//  S changes only in DECODE; stable through EXEC.
// STRUCTURE
//  Package cu_pkg: state enum (S_FETCH,S_IFETCH,S_DECODE,S_EXEC,S_HALT), default bit positions, S codes.
//  Sub-module onehot_idx #(N,W): one-hot -> index+1, zero flag, multi-hot flag; combinational.
//  Top: registered FSM, outputs decoded from state + Mem_Ack; watchdog and Instr_Cnt counters.
// TESTING
//  IR=16'h0001, Ack same cycle -> Load_AR,Load_IR,(DECODE),Load_AC at cycles 0,1,3; S=1; Instr_Cnt=1.
//  IR=16'h0210 (read+xor), Ack delayed 3 cycles -> Rd/Mem_Req held 3 cycles; Load_OR&Load_AC on Ack; S=5.
//  IR=16'h0003 -> Illegal=1 sticky, no Load_AC, Instr_Cnt unchanged, next Load_AR next cycle.
//  IR=16'h0100, Mem_Ack never -> Timeout pulse after WAIT_MAX=15 cycles, back to S_FETCH.
//  IR=16'h8000 -> Halted=1, no strobes for 100 cycles; Reset -> Halted=0, Load_AR after Reset drops.
//  Run=0 for 5 cycles, Reset mid S_EXEC wait, CNT_W=2 wrap 3->0 after 4th retire.

Source files
------------

// File: rtl/ctrl_unit_mc_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg
//   Shared definitions for the multi-cycle accumulator-CPU control unit:
//   FSM state encoding, default instruction bit positions and widths,
//   and the ALU select code meaning "no ALU operation".
// -----------------------------------------------------------------------------
package cu_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_IFETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam int unsigned DEF_IW       = 16;
    localparam int unsigned DEF_ALU_OPS  = 8;
    localparam int unsigned DEF_SW       = 4;
    localparam int unsigned DEF_RD_BIT   = 9;
    localparam int unsigned DEF_WR_BIT   = 8;
    localparam int unsigned DEF_HLT_BIT  = 15;
    localparam int unsigned DEF_WAIT_MAX = 15;
    localparam int unsigned DEF_CNT_W    = 16;

    // ALU select value meaning "no ALU op"; real ops are bit index + 1
    localparam int unsigned S_CODE_NONE  = 0;

endpackage

// File: rtl/ctrl_unit_mc_onehot_idx.sv
// -----------------------------------------------------------------------------
// onehot_idx
//   Combinational one-hot decoder: reports the position of the set bit as
//   index+1 (0 when no bit is set), plus zero and multi-hot flags.
//   vec   in  N  one-hot input field
//   idx   out W  index+1 of the highest set bit, 0 if none
//   zero  out 1  no bit set
//   multi out 1  more than one bit set
// -----------------------------------------------------------------------------
module onehot_idx #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 4
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         zero,
    output logic         multi
);

    logic seen;

    always_comb begin
        idx   = '0;
        multi = 1'b0;
        seen  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
                idx  = W'(i + 1);
            end
        end
        zero = ~seen;
    end

endmodule

// File: rtl/ctrl_unit_mc.sv
// -----------------------------------------------------------------------------
// ctrl_unit_mc
//   Multi-cycle control unit: FETCH -> IFETCH -> DECODE -> EXEC with a
//   Req/Ack memory handshake, halt, run gating, illegal-instruction detection,
//   memory-wait watchdog and a retired-instruction counter.
//   Clock_Puls in  1     clock (rising edge)
//   Reset      in  1     synchronous active-high reset
//   Run        in  1     allow a new fetch (sampled in S_FETCH)
//   IR         in  IW    instruction register contents
//   Mem_Ack    in  1     memory completes current request
//   Mem_Req/Rd/Wr   out  memory request, read, write
//   Load_AR/IR/AC/OR out datapath load strobes
//   S          out SW    registered ALU select, 0 = none
//   Halted     out 1     in S_HALT
//   Illegal    out 1     sticky illegal-instruction flag
//   Timeout    out 1     watchdog expiry pulse
//   Instr_Cnt  out CNT_W retired instructions (wrapping)
// -----------------------------------------------------------------------------
module ctrl_unit_mc
    import cu_pkg::*;
#(
    parameter int unsigned IW       = DEF_IW,
    parameter int unsigned ALU_OPS  = DEF_ALU_OPS,
    parameter int unsigned SW       = DEF_SW,
    parameter int unsigned RD_BIT   = DEF_RD_BIT,
    parameter int unsigned WR_BIT   = DEF_WR_BIT,
    parameter int unsigned HLT_BIT  = DEF_HLT_BIT,
    parameter int unsigned WAIT_MAX = DEF_WAIT_MAX,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             Clock_Puls,
    input  logic             Reset,
    input  logic             Run,
    input  logic [IW-1:0]    IR,
    input  logic             Mem_Ack,
    output logic             Mem_Req,
    output logic             Rd,
    output logic             Wr,
    output logic             Load_AR,
    output logic             Load_IR,
    output logic             Load_AC,
    output logic             Load_OR,
    output logic [SW-1:0]    S,
    output logic             Halted,
    output logic             Illegal,
    output logic             Timeout,
    output logic [CNT_W-1:0] Instr_Cnt
);

    localparam int unsigned WC_W = $clog2(WAIT_MAX + 1);

    state_t          state;
    state_t          state_next;
    logic [WC_W-1:0] wait_cnt;
    logic [SW-1:0]   alu_idx;
    logic            alu_zero;
    logic            alu_multi;
    logic            rd_op;
    logic            wr_op;
    logic            hlt_op;
    logic            mem_op;
    logic            illegal_ir;
    logic            wait_hit;
    logic            alu_active;
    logic            retire;
    logic            unused_ir;

    onehot_idx #(
        .N (ALU_OPS),
        .W (SW)
    ) u_alu_dec (
        .vec   (IR[ALU_OPS-1:0]),
        .idx   (alu_idx),
        .zero  (alu_zero),
        .multi (alu_multi)
    );

    assign rd_op      = IR[RD_BIT];
    assign wr_op      = IR[WR_BIT];
    assign hlt_op     = IR[HLT_BIT];
    assign mem_op     = rd_op | wr_op;
    assign illegal_ir = alu_multi | (rd_op & wr_op);
    assign alu_active = (S != SW'(S_CODE_NONE));
    // Last permitted waiting cycle: without Ack now, the request is abandoned
    assign wait_hit   = (wait_cnt == WC_W'(WAIT_MAX - 1));
    assign retire     = !Reset && (state == S_EXEC) && (!mem_op || Mem_Ack);
    assign unused_ir  = ^IR;

    // State register
    always_ff @(posedge Clock_Puls) begin
        if (Reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH: begin
                if (Run) begin
                    state_next = S_IFETCH;
                end
            end
            S_IFETCH: begin
                if (Mem_Ack || wait_hit) begin
                    state_next = Mem_Ack ? S_DECODE : S_FETCH;
                end
            end
            S_DECODE: begin
                if (hlt_op) begin
                    state_next = S_HALT;
                end else if (illegal_ir) begin
                    state_next = S_FETCH;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!mem_op || Mem_Ack || wait_hit) begin
                    state_next = S_FETCH;
                end
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    // Output decode; everything is forced low while Reset is asserted so an
    // outstanding request is dropped in the reset cycle itself
    always_comb begin
        Mem_Req = 1'b0;
        Rd      = 1'b0;
        Wr      = 1'b0;
        Load_AR = 1'b0;
        Load_IR = 1'b0;
        Load_AC = 1'b0;
        Load_OR = 1'b0;
        Halted  = 1'b0;
        Timeout = 1'b0;
        if (!Reset) begin
            unique case (state)
                S_FETCH: Load_AR = Run;
                S_IFETCH: begin
                    Mem_Req = 1'b1;
                    Rd      = 1'b1;
                    Load_IR = Mem_Ack;
                    Timeout = !Mem_Ack && wait_hit;
                end
                S_DECODE: ;
                S_EXEC: begin
                    if (rd_op) begin
                        Mem_Req = 1'b1;
                        Rd      = 1'b1;
                        Load_OR = Mem_Ack;
                        Load_AC = Mem_Ack && alu_active;
                        Timeout = !Mem_Ack && wait_hit;
                    end else if (wr_op) begin
                        Mem_Req = 1'b1;
                        Wr      = 1'b1;
                        Load_AC = Mem_Ack && alu_active;
                        Timeout = !Mem_Ack && wait_hit;
                    end else begin
                        Load_AC = alu_active;
                    end
                end
                S_HALT:  Halted = 1'b1;
                default: ;
            endcase
        end
    end

    // ALU select, illegal flag, retire counter and memory watchdog
    always_ff @(posedge Clock_Puls) begin
        if (Reset) begin
            S         <= '0;
            Illegal   <= 1'b0;
            Instr_Cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (state == S_DECODE && !hlt_op) begin
                if (illegal_ir || alu_zero) begin
                    S <= SW'(S_CODE_NONE);
                end else begin
                    S <= alu_idx;
                end
                if (illegal_ir) begin
                    Illegal <= 1'b1;
                end
            end
            if (retire) begin
                Instr_Cnt <= Instr_Cnt + 1'b1;
            end
            if (!Mem_Req || Mem_Ack || Timeout) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// -----------------------------------------------------------------------------
// tb_ctrl_unit_mc
//   Directed bench for ctrl_unit_mc (CNT_W=2 so the counter wrap is reachable).
//   Each driven cycle pushes its expected outputs to a scoreboard queue; a
//   negedge monitor pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_ctrl_unit_mc;

    localparam logic [8:0] MREQ = 9'h100;
    localparam logic [8:0] RD   = 9'h080;
    localparam logic [8:0] WR   = 9'h040;
    localparam logic [8:0] LAR  = 9'h020;
    localparam logic [8:0] LIR  = 9'h010;
    localparam logic [8:0] LAC  = 9'h008;
    localparam logic [8:0] LOR  = 9'h004;
    localparam logic [8:0] HLT  = 9'h002;
    localparam logic [8:0] TMO  = 9'h001;
    localparam logic [8:0] NONE = 9'h000;

    typedef struct packed {
        logic [8:0] str;
        logic [3:0] s;
        logic       ill;
        logic [1:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Run = 1'b0;
    logic [15:0] IR = '0;
    logic        Mem_Ack = 1'b0;
    logic        Mem_Req, Rd, Wr, Load_AR, Load_IR, Load_AC, Load_OR;
    logic [3:0]  S;
    logic        Halted, Illegal, Timeout;
    logic [1:0]  Instr_Cnt;

    exp_t        sb_exp[$];
    string       sb_tag[$];
    exp_t        e;
    string       t;
    logic [8:0]  obs;
    int          n_assert = 0;
    int          n_fail = 0;

    logic [15:0] cur_ir = '0;
    logic [3:0]  exp_s = '0;
    logic        exp_ill = 1'b0;
    logic [1:0]  exp_cnt = '0;

    ctrl_unit_mc #(
        .CNT_W (2)
    ) dut (
        .Clock_Puls (clk),
        .Reset      (Reset),
        .Run        (Run),
        .IR         (IR),
        .Mem_Ack    (Mem_Ack),
        .Mem_Req    (Mem_Req),
        .Rd         (Rd),
        .Wr         (Wr),
        .Load_AR    (Load_AR),
        .Load_IR    (Load_IR),
        .Load_AC    (Load_AC),
        .Load_OR    (Load_OR),
        .S          (S),
        .Halted     (Halted),
        .Illegal    (Illegal),
        .Timeout    (Timeout),
        .Instr_Cnt  (Instr_Cnt)
    );

    always #5 clk = ~clk;

    // Monitor: compare the cycle driven after the last posedge
    always @(negedge clk) begin
        if (sb_exp.size() != 0) begin
            e   = sb_exp.pop_front();
            t   = sb_tag.pop_front();
            obs = {Mem_Req, Rd, Wr, Load_AR, Load_IR, Load_AC, Load_OR, Halted, Timeout};
            n_assert++;
            assert (obs === e.str) else begin
                n_fail++;
                $error("FAIL %s strobes: got %h expected %h", t, obs, e.str);
            end
            n_assert++;
            assert (S === e.s) else begin
                n_fail++;
                $error("FAIL %s S: got %0d expected %0d", t, S, e.s);
            end
            n_assert++;
            assert (Illegal === e.ill) else begin
                n_fail++;
                $error("FAIL %s Illegal: got %b expected %b", t, Illegal, e.ill);
            end
            n_assert++;
            assert (Instr_Cnt === e.cnt) else begin
                n_fail++;
                $error("FAIL %s Instr_Cnt: got %0d expected %0d", t, Instr_Cnt, e.cnt);
            end
        end
    end

    task automatic cyc(input string tag, input logic run_v, input logic ack_v,
                       input logic rst_v, input logic [8:0] str);
        exp_t x;
        @(posedge clk);
        #1;
        Reset   = rst_v;
        Run     = run_v;
        Mem_Ack = ack_v;
        IR      = cur_ir;
        x.str = str;
        x.s   = exp_s;
        x.ill = exp_ill;
        x.cnt = exp_cnt;
        sb_exp.push_back(x);
        sb_tag.push_back(tag);
    endtask

    // FETCH, IFETCH with same-cycle Ack, DECODE
    task automatic front(input string tag, input logic [15:0] ir_v);
        cur_ir = ir_v;
        cyc({tag, "_fetch"}, 1'b1, 1'b0, 1'b0, LAR);
        cyc({tag, "_ifetch"}, 1'b1, 1'b1, 1'b0, MREQ | RD | LIR);
        cyc({tag, "_decode"}, 1'b0, 1'b0, 1'b0, NONE);
    endtask

    initial begin
        // Reset held: everything low, Ack and Run ignored
        cyc("reset", 1'b1, 1'b1, 1'b1, NONE);
        cyc("reset2", 1'b1, 1'b0, 1'b1, NONE);

        // ALU-only op, S=1, 4 cycles
        front("alu", 16'h0001);
        exp_s = 4'd1;
        cyc("alu_exec", 1'b0, 1'b0, 1'b0, LAC);
        exp_cnt = 2'd1;

        // Read + xor, Ack delayed 3 cycles, S=5
        front("rdx", 16'h0210);
        exp_s = 4'd5;
        for (int i = 0; i < 3; i++) cyc("rdx_wait", 1'b0, 1'b0, 1'b0, MREQ | RD);
        cyc("rdx_ack", 1'b0, 1'b1, 1'b0, MREQ | RD | LOR | LAC);
        exp_cnt = 2'd2;

        // Illegal multi-hot: back to FETCH, no retire
        front("ill", 16'h0003);
        exp_s   = 4'd0;
        exp_ill = 1'b1;

        // Write with no Ack: timeout on the 15th waiting cycle (Ack in FETCH ignored)
        cur_ir = 16'h0100;
        cyc("wto_fetch", 1'b1, 1'b1, 1'b0, LAR);
        cyc("wto_ifetch", 1'b1, 1'b1, 1'b0, MREQ | RD | LIR);
        cyc("wto_decode", 1'b0, 1'b0, 1'b0, NONE);
        for (int i = 0; i < 14; i++) cyc("wto_wait", 1'b0, 1'b0, 1'b0, MREQ | WR);
        cyc("wto_expire", 1'b0, 1'b0, 1'b0, MREQ | WR | TMO);

        // Write with Ack exactly at expiry: Ack wins, retires, S=0 so no Load_AC
        front("wack", 16'h0100);
        for (int i = 0; i < 14; i++) cyc("wack_wait", 1'b0, 1'b0, 1'b0, MREQ | WR);
        cyc("wack_ack", 1'b0, 1'b1, 1'b0, MREQ | WR);
        exp_cnt = 2'd3;

        // Run low holds in FETCH
        for (int i = 0; i < 5; i++) cyc("run_low", 1'b0, 1'b1, 1'b0, NONE);

        // Slow instruction fetch, S=8, fourth retire wraps counter
        cur_ir = 16'h0080;
        cyc("wrap_fetch", 1'b1, 1'b0, 1'b0, LAR);
        for (int i = 0; i < 2; i++) cyc("wrap_iwait", 1'b0, 1'b0, 1'b0, MREQ | RD);
        cyc("wrap_ifetch", 1'b0, 1'b1, 1'b0, MREQ | RD | LIR);
        cyc("wrap_decode", 1'b0, 1'b0, 1'b0, NONE);
        exp_s = 4'd8;
        cyc("wrap_exec", 1'b0, 1'b0, 1'b0, LAC);
        exp_cnt = 2'd0;

        // Reset in the middle of an EXEC read wait
        front("rst", 16'h0200);
        exp_s = 4'd0;
        for (int i = 0; i < 2; i++) cyc("rst_wait", 1'b0, 1'b0, 1'b0, MREQ | RD);
        cyc("rst_hit", 1'b1, 1'b1, 1'b1, NONE);
        exp_ill = 1'b0;

        // Post-reset instruction, then halt holding S=1
        front("post", 16'h0001);
        exp_s = 4'd1;
        cyc("post_exec", 1'b0, 1'b0, 1'b0, LAC);
        exp_cnt = 2'd1;
        front("halt", 16'h8000);
        for (int i = 0; i < 100; i++)
            cyc("halted", logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 1'b0, HLT);
        cyc("halt_rst", 1'b1, 1'b0, 1'b1, NONE);
        exp_s   = 4'd0;
        exp_cnt = 2'd0;
        cyc("after_rst", 1'b1, 1'b0, 1'b0, LAR);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
